// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_pkg
// Description : Shared constants and types for the matrix BRAM streaming path.
//               Holds the BRAM geometry, the reader FSM state type and the
//               tagged element carried through the output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 9216;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int DIM_WIDTH  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } reader_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  row_last;
    logic                  last;
  } elem_tag_t;

endpackage
`default_nettype wire

// File: rtl/stream_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo2
// Description : Two-entry register FIFO of tagged matrix elements.
//               Push and pop may happen in the same cycle, including when
//               the FIFO is full.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               push, push_data - write strobe and element
//               pop             - read strobe (ignored when empty)
//               head            - oldest element (valid when count != 0)
//               count           - occupancy, 0..2
// Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo2
  import matrix_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  elem_tag_t push_data,
  input  logic      pop,
  output elem_tag_t head,
  output logic [1:0] count
);

  elem_tag_t  r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_pop  = pop & (r_count != 2'd0);
  // A full FIFO can still accept a push when the head leaves the same cycle.
  assign w_do_push = push & ((r_count != 2'd2) | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/matrix_bram_reader.sv
`default_nettype none
// ============================================================================
// Module      : matrix_bram_reader
// Description : Streams one rows x cols matrix out of a single-port BRAM with
//               1-cycle read latency, in row-major order, over valid/ready.
//               Read data is buffered in a 2-entry FIFO; when the FIFO is
//               empty the BRAM output is forwarded straight to the stream so
//               the first beat appears two cycles after start.
// Ports       : clk, rst_n              - clock, async active-low reset
//               start, base_addr,
//               rows, cols              - transfer request (sampled in IDLE)
//               bram_addr, bram_dout    - BRAM read port
//               m_valid, m_ready,
//               m_data, m_row_last,
//               m_last                  - output element stream
//               busy, done, err         - status
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_bram_reader #(
  parameter int DATA_WIDTH = matrix_pkg::DATA_WIDTH,
  parameter int DEPTH      = matrix_pkg::DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int DIM_WIDTH  = matrix_pkg::DIM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DIM_WIDTH-1:0]  rows,
  input  logic [DIM_WIDTH-1:0]  cols,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_row_last,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  import matrix_pkg::*;

  localparam logic [ADDR_WIDTH:0] c_depth_ext = (ADDR_WIDTH+1)'(DEPTH);

  reader_state_t r_state;
  reader_state_t w_next_state;

  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_total;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [DIM_WIDTH-1:0]  r_cols;
  logic [DIM_WIDTH-1:0]  r_col;
  logic [ADDR_WIDTH-1:0] r_bram_addr;
  logic                  r_issue_q;
  logic                  r_issue_row_last;
  logic                  r_issue_last;
  logic                  r_err;

  logic [2*DIM_WIDTH-1:0] w_prod;
  logic [ADDR_WIDTH-1:0]  w_total;
  logic [ADDR_WIDTH:0]    w_end;
  logic                   w_shape_ok;
  logic                   w_start_idle;
  logic                   w_accept;
  logic                   w_reject;
  logic                   w_issue;
  logic                   w_issue_row_last;
  logic                   w_issue_last;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [1:0]             w_fifo_count;
  logic [1:0]             w_pending;
  logic                   w_fifo_empty;
  logic                   w_fifo_push;
  logic                   w_fifo_pop;
  elem_tag_t              w_fifo_head;
  elem_tag_t              w_bram_elem;
  elem_tag_t              w_out;
  logic                   w_fire;

  // --------------------------------------------------------------------------
  // Request validation: bounds are checked one bit wider than the address so
  // a transfer ending exactly at DEPTH is accepted and nothing wraps.
  // --------------------------------------------------------------------------
  assign w_prod       = rows * cols;
  assign w_total      = ADDR_WIDTH'(w_prod);
  assign w_end        = {1'b0, base_addr} + {1'b0, w_total};
  assign w_shape_ok   = (rows != '0) && (cols != '0) && (w_end <= c_depth_ext);
  assign w_start_idle = start && (r_state == IDLE);
  assign w_accept     = w_start_idle && w_shape_ok;
  assign w_reject     = w_start_idle && !w_shape_ok;

  // --------------------------------------------------------------------------
  // Issue logic: buffered plus in-flight elements never exceed the 2 slots,
  // so every read that returns always has a place to land.
  // --------------------------------------------------------------------------
  assign w_pending        = w_fifo_count + {1'b0, r_issue_q};
  assign w_issue          = (r_state == READ) && (w_pending < 2'd2);
  assign w_issue_row_last = (r_col == r_cols - DIM_WIDTH'(1));
  assign w_issue_last     = (r_idx == r_total - ADDR_WIDTH'(1));
  assign w_addr           = r_base + r_idx;

  // Address holds between issues; a repeated BRAM read is harmless.
  assign bram_addr = w_issue ? w_addr : r_bram_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base           <= '0;
      r_total          <= '0;
      r_idx            <= '0;
      r_cols           <= '0;
      r_col            <= '0;
      r_bram_addr      <= '0;
      r_issue_q        <= 1'b0;
      r_issue_row_last <= 1'b0;
      r_issue_last     <= 1'b0;
      r_err            <= 1'b0;
    end else begin
      r_err            <= w_reject;
      r_issue_q        <= w_issue;
      r_issue_row_last <= w_issue_row_last;
      r_issue_last     <= w_issue_last;
      if (w_accept) begin
        // Row count is only needed through the total, so it is not kept.
        r_base  <= base_addr;
        r_cols  <= cols;
        r_total <= w_total;
        r_idx   <= '0;
        r_col   <= '0;
      end else if (w_issue) begin
        r_bram_addr <= w_addr;
        r_idx       <= r_idx + ADDR_WIDTH'(1);
        r_col       <= w_issue_row_last ? '0 : r_col + DIM_WIDTH'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output buffer with bypass: when the FIFO is empty, returning BRAM data is
  // presented directly and only stored if the consumer stalls.
  // --------------------------------------------------------------------------
  assign w_bram_elem.data     = bram_dout;
  assign w_bram_elem.row_last = r_issue_row_last;
  assign w_bram_elem.last     = r_issue_last;

  assign w_fifo_empty = (w_fifo_count == 2'd0);
  assign w_fifo_pop   = !w_fifo_empty && m_ready;
  assign w_fifo_push  = r_issue_q && !(w_fifo_empty && m_ready);

  stream_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_fifo_push),
    .push_data (w_bram_elem),
    .pop       (w_fifo_pop),
    .head      (w_fifo_head),
    .count     (w_fifo_count)
  );

  always_comb begin
    w_out = '0;
    if (!w_fifo_empty) begin
      w_out = w_fifo_head;
    end else if (r_issue_q) begin
      w_out = w_bram_elem;
    end
  end

  assign m_valid    = !w_fifo_empty || r_issue_q;
  assign m_data     = w_out.data;
  assign m_row_last = w_out.row_last;
  assign m_last     = w_out.last;
  assign w_fire     = m_valid && m_ready;
  assign err        = r_err;

  // --------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = READ;
      READ:    if (w_issue && w_issue_last) w_next_state = DRAIN;
      DRAIN:   if (w_fire && m_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      READ, DRAIN: busy = 1'b1;
      DONE:        done = 1'b1;
      default:     ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_bram_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_matrix_bram_reader
// Description : Self-checking bench for matrix_bram_reader. A BRAM model feeds
//               the DUT; an expected-beat queue built from the matrix shape is
//               compared against every stream handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_bram_reader;
  import matrix_pkg::*;

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [AW-1:0]        base_addr = '0;
  logic [DIM_WIDTH-1:0] rows = '0;
  logic [DIM_WIDTH-1:0] cols = '0;
  logic [AW-1:0]        bram_addr;
  logic [DW-1:0]        bram_dout;
  logic                 m_valid;
  logic                 m_ready = 1'b1;
  logic [DW-1:0]        m_data;
  logic                 m_row_last;
  logic                 m_last;
  logic                 busy;
  logic                 done;
  logic                 err;

  matrix_bram_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .rows       (rows),
    .cols       (cols),
    .bram_addr  (bram_addr),
    .bram_dout  (bram_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_row_last (m_row_last),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:16383];
  always @(posedge clk) bram_dout <= mem[bram_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int err_cnt = 0;
  int exp_err = 0;
  int beats = 0;
  int rl_cnt = 0;
  int last_cnt = 0;
  int last_beat_cyc = 0;
  int start_cyc = 0;
  bit rand_ready = 1'b0;
  logic [DW+1:0] exp_q [$];
  logic          prev_stall = 1'b0;
  logic [DW+1:0] prev_out = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Consumer readiness: always ready, or a fair coin each cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every handshake against the expected queue, plus
  // stream stability under stall and done/err bookkeeping.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_hold", 64'({m_data, m_row_last, m_last}), 64'(prev_out));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          chk("beat", 64'({m_data, m_row_last, m_last}), 64'(exp_q.pop_front()));
        end
        beats++;
        if (m_row_last) rl_cnt++;
        if (m_last) last_cnt++;
        last_beat_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("done_busy_low", 64'(busy), 64'd0);
      end
      if (err) err_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_data, m_row_last, m_last};
    end
  end

  // Enter at posedge+1; leaves at the negedge of the first cycle after start.
  task automatic do_start(input int b, input int r, input int c, output bit acc);
    acc = (r != 0) && (c != 0) && (b + r * c <= DEPTH);
    if (!acc) exp_err++;
    if (acc) begin
      for (int i = 0; i < r * c; i++) begin
        exp_q.push_back({mem[b + i], (i % c) == c - 1, i == r * c - 1});
      end
    end
    base_addr = AW'(b);
    rows      = DIM_WIDTH'(r);
    cols      = DIM_WIDTH'(c);
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_after_start", 64'(err), 64'(!acc));
    chk("busy_after_start", 64'(busy), 64'(acc));
  endtask

  // Leaves at posedge+1 of the cycle following the done pulse.
  task automatic wait_done(input int snap);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (done_cnt == snap && n < 3000);
    if (done_cnt == snap) chk("done_timeout", 64'd0, 64'd1);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    int snap, b0, rl0, ls0, n, r, c, b;

    for (int i = 0; i < 16384; i++) mem[i] = $urandom;

    // Reset values
    @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_bram_addr", 64'(bram_addr), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(2);

    // 2x3 at base 100, always ready: exact timing
    snap = done_cnt; b0 = beats; rl0 = rl_cnt; ls0 = last_cnt;
    do_start(100, 2, 3, acc);
    chk("first_addr", 64'(bram_addr), 64'd100);
    chk("no_valid_at_start_plus1", 64'(m_valid), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("addr_seq", 64'(bram_addr), 64'(100 + k));
      if (k == 1) chk("valid_at_start_plus2", 64'(m_valid), 64'd1);
    end
    wait_done(snap);
    chk("2x3_beats", 64'(beats - b0), 64'd6);
    chk("2x3_row_last_count", 64'(rl_cnt - rl0), 64'd2);
    chk("2x3_last_count", 64'(last_cnt - ls0), 64'd1);
    chk("2x3_done_latency", 64'(done_cyc - start_cyc), 64'd8);
    chk("2x3_done_after_beat", 64'(done_cyc - last_beat_cyc), 64'd1);

    // 4x4 at base 0 with random backpressure
    rand_ready = 1'b1;
    snap = done_cnt; b0 = beats;
    do_start(0, 4, 4, acc);
    wait_done(snap);
    chk("4x4_beats", 64'(beats - b0), 64'd16);

    // Rejections and boundary acceptance
    b0 = beats;
    do_start(0, 0, 5, acc);
    idle_cycles(4);
    chk("reject_no_beats", 64'(beats - b0), 64'd0);
    do_start(9200, 3, 10, acc);
    idle_cycles(4);
    chk("reject_oob_busy", 64'(busy), 64'd0);
    snap = done_cnt; b0 = beats;
    do_start(9186, 3, 10, acc);
    wait_done(snap);
    chk("edge_3x10_beats", 64'(beats - b0), 64'd30);

    // 1x1 at the last word
    snap = done_cnt; b0 = beats; rl0 = rl_cnt; ls0 = last_cnt;
    do_start(9215, 1, 1, acc);
    wait_done(snap);
    chk("1x1_beats", 64'(beats - b0), 64'd1);
    chk("1x1_row_last", 64'(rl_cnt - rl0), 64'd1);
    chk("1x1_last", 64'(last_cnt - ls0), 64'd1);

    // start while busy is ignored
    snap = done_cnt; b0 = beats;
    do_start(10, 3, 3, acc);
    @(posedge clk);
    #1;
    base_addr = '0; rows = 6'd1; cols = 6'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_start_no_err", 64'(err), 64'd0);
    wait_done(snap);
    idle_cycles(5);
    chk("busy_start_beats", 64'(beats - b0), 64'd9);
    chk("busy_start_one_done", 64'(done_cnt - snap), 64'd1);

    // Reset during beat 4 of a 3x3
    rand_ready = 1'b0;
    snap = done_cnt; b0 = beats;
    do_start(200, 3, 3, acc);
    n = 0;
    while (beats - b0 < 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (beats - b0 < 3) chk("reset_wait_timeout", 64'd0, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(1);
    chk("midrst_no_done", 64'(done_cnt - snap), 64'd0);
    snap = done_cnt; b0 = beats;
    do_start(50, 2, 2, acc);
    wait_done(snap);
    chk("post_rst_2x2_beats", 64'(beats - b0), 64'd4);

    // Randomized shapes, bases and backpressure, starts back-to-back after done
    rand_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      r = $urandom_range(0, 8);
      c = $urandom_range(0, 8);
      b = (t % 4 == 0) ? DEPTH - $urandom_range(0, 60) : $urandom_range(0, DEPTH - 1);
      snap = done_cnt; b0 = beats;
      do_start(b, r, c, acc);
      if (acc) begin
        wait_done(snap);
        chk("rand_beats", 64'(beats - b0), 64'(r * c));
      end else begin
        idle_cycles(3);
        chk("rand_reject_beats", 64'(beats - b0), 64'd0);
      end
    end

    idle_cycles(3);
    chk("err_pulse_total", 64'(err_cnt), 64'(exp_err));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
